red_pitaya_pwm_gen: RTL

RED_PITAYA_PWM_GEN -- requirements
Module: red_pitaya_pwm_gen

---
 rtl/red_pitaya_pwm_gen.sv | 81 ++++++++
 1 files changed

// File: rtl/red_pitaya_pwm_gen.sv
// ---------------------------------------------------------------------------
// red_pitaya_pwm_gen
//
// Dithered PWM generator for an analog-filter output pin. One period is 256
// clocks; 16 periods form a frame. In period k the high time is the base duty
// D plus dither bit S[k], so the frame-average duty is (16*D + popcount(S))
// over 4096 clocks. The configuration word is shadowed and reloaded only at
// the last clock of a frame, so a frame is never built from a mixed setting.
//
// Ports
//   clk_i   : PWM clock, all logic on the rising edge
//   rstn_i  : synchronous active-low reset
//   cfg_i   : configuration, [23:16] base duty D, [15:0] dither sequence S
//   pwm_o   : registered PWM bit
//   sync_o  : registered one-clock strobe on the first pwm_o bit of a frame
//   cfg_o   : active (shadowed) configuration for readback
// ---------------------------------------------------------------------------
module red_pitaya_pwm_gen #(
  parameter int unsigned CCW = 24
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic [CCW-1:0] cfg_i,
  output logic           pwm_o,
  output logic           sync_o,
  output logic [CCW-1:0] cfg_o
);

  logic [7:0]     cnt_q, cnt_d;
  logic [3:0]     frm_q, frm_d;
  logic [CCW-1:0] cfg_q, cfg_d;
  logic           pwm_q, pwm_d;
  logic           sync_q, sync_d;

  logic           period_end;
  logic           frame_end;
  logic [7:0]     duty;
  logic [15:0]    dither;
  logic [8:0]     high_time;

  always_comb begin
    period_end = (cnt_q == 8'hFF);
    frame_end  = period_end && (frm_q == 4'hF);

    cnt_d = cnt_q + 8'd1;
    frm_d = period_end ? frm_q + 4'd1 : frm_q;

    // The load edge samples cfg_i as it is on that very edge.
    cfg_d = frame_end ? cfg_i : cfg_q;

    duty   = cfg_q[23:16];
    dither = cfg_q[15:0];

    // 9 bits so that D=255 with a dither bit of 1 reaches 256 (always high).
    high_time = {1'b0, duty} + {8'd0, dither[frm_q]};

    pwm_d  = ({1'b0, cnt_q} < high_time);
    sync_d = (cnt_q == 8'd0) && (frm_q == 4'd0);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q  <= 8'd0;
      frm_q  <= 4'd0;
      cfg_q  <= '0;
      pwm_q  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      frm_q  <= frm_d;
      cfg_q  <= cfg_d;
      pwm_q  <= pwm_d;
      sync_q <= sync_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign sync_o = sync_q;
  assign cfg_o  = cfg_q;

endmodule
